// File: rtl/event_order_pkg.sv
// ============================================================================
// Module      : event_order_pkg
// Description : Shared types and helpers for the event order monitor.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package event_order_pkg;

    localparam int MAX_EVENTS = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_EVT = 2'd1,
        PASS     = 2'd2,
        FAIL     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FAIL_NONE    = 2'b00,
        FAIL_ORDER   = 2'b01,
        FAIL_MULTI   = 2'b10,
        FAIL_TIMEOUT = 2'b11
    } fail_code_e;

    // True when two or more bits of the vector are set.
    function automatic logic multi_hot(input logic [MAX_EVENTS-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/event_timeout_counter.sv
// ============================================================================
// Module      : event_timeout_counter
// Description : Saturating idle-cycle counter with limit-reached flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module event_timeout_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_incr,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_count_p1;

    // One extra bit so a saturated count can never alias a small limit.
    assign w_count_p1 = {1'b0, r_count} + 1'b1;
    assign o_expired  = (i_limit != '0) && (w_count_p1 == {1'b0, i_limit});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_incr && (r_count != '1)) begin
            r_count <= w_count_p1[WIDTH-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/event_order_monitor.sv
// ============================================================================
// Module      : event_order_monitor
// Description : Checks that one-hot event pulses arrive in ascending order.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module event_order_monitor
    import event_order_pkg::*;
#(
    parameter int NUM_EVENTS   = 4,
    parameter int TIMEOUT_W    = 8,
    parameter int ALLOW_REPEAT = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [NUM_EVENTS-1:0]           events,
    input  logic [TIMEOUT_W-1:0]            timeout_limit,
    output logic                            busy,
    output logic                            done,
    output logic                            fail,
    output logic [1:0]                      fail_code,
    output logic [$clog2(NUM_EVENTS)-1:0]   fail_index,
    output logic [$clog2(NUM_EVENTS+1)-1:0] progress
);

    localparam int IDX_W  = $clog2(NUM_EVENTS);
    localparam int PROG_W = $clog2(NUM_EVENTS + 1);

    state_e              r_state,      w_state_nxt;
    logic [PROG_W-1:0]   r_progress,   w_progress_nxt;
    fail_code_e          r_fail_code,  w_fail_code_nxt;
    logic [IDX_W-1:0]    r_fail_index, w_fail_index_nxt;

    logic                  w_tmr_clear;
    logic                  w_tmr_incr;
    logic                  w_tmr_expired;
    logic [IDX_W-1:0]      w_idx;
    logic [NUM_EVENTS-1:0] w_expect;
    logic [NUM_EVENTS-1:0] w_prev;
    logic                  w_multi;
    logic                  w_repeat;
    logic                  w_last;
    logic                  w_arm;

    // Accepted-event count doubles as the expected index while checking.
    assign w_idx    = r_progress[IDX_W-1:0];
    assign w_expect = NUM_EVENTS'(1) << w_idx;
    assign w_prev   = NUM_EVENTS'(1) << (w_idx - 1'b1);
    assign w_multi  = multi_hot(MAX_EVENTS'(events));
    assign w_repeat = (ALLOW_REPEAT != 0) && (w_idx != '0) && (events == w_prev);
    assign w_last   = (w_idx == IDX_W'(NUM_EVENTS - 1));
    assign w_arm    = start && ((r_state == IDLE) || (r_state == WAIT_EVT));

    event_timeout_counter #(
        .WIDTH (TIMEOUT_W)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_tmr_clear),
        .i_incr    (w_tmr_incr),
        .i_limit   (timeout_limit),
        .o_expired (w_tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_progress   <= '0;
            r_fail_code  <= FAIL_NONE;
            r_fail_index <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_progress   <= w_progress_nxt;
            r_fail_code  <= w_fail_code_nxt;
            r_fail_index <= w_fail_index_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_progress_nxt   = r_progress;
        w_fail_code_nxt  = r_fail_code;
        w_fail_index_nxt = r_fail_index;
        w_tmr_clear      = 1'b0;
        w_tmr_incr       = 1'b0;

        if (w_arm) begin
            w_state_nxt      = WAIT_EVT;
            w_progress_nxt   = '0;
            w_fail_code_nxt  = FAIL_NONE;
            w_fail_index_nxt = '0;
            w_tmr_clear      = 1'b1;
        end else begin
            case (r_state)
                WAIT_EVT: begin
                    if (events == '0) begin
                        if (w_tmr_expired) begin
                            w_state_nxt      = FAIL;
                            w_fail_code_nxt  = FAIL_TIMEOUT;
                            w_fail_index_nxt = w_idx;
                        end else begin
                            w_tmr_incr = 1'b1;
                        end
                    end else if (w_multi) begin
                        w_state_nxt      = FAIL;
                        w_fail_code_nxt  = FAIL_MULTI;
                        w_fail_index_nxt = w_idx;
                    end else if (events == w_expect) begin
                        w_progress_nxt = r_progress + 1'b1;
                        w_tmr_clear    = 1'b1;
                        if (w_last) begin
                            w_state_nxt = PASS;
                        end
                    end else if (!w_repeat) begin
                        w_state_nxt      = FAIL;
                        w_fail_code_nxt  = FAIL_ORDER;
                        w_fail_index_nxt = w_idx;
                    end
                end
                PASS, FAIL: w_state_nxt = IDLE;
                default:    w_state_nxt = IDLE;
            endcase
        end
    end

    assign busy       = (r_state == WAIT_EVT);
    assign done       = (r_state == PASS);
    assign fail       = (r_state == FAIL);
    assign fail_code  = r_fail_code;
    assign fail_index = r_fail_index;
    assign progress   = r_progress;

endmodule

`default_nettype wire
